// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: synchronises rx, validates the start bit at
// mid-bit, centre-samples data/parity/stop and reports word, done pulse and flags.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OS_RATE    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OS_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OS_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);
  localparam logic          PAR_EN   = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_r;
  logic [1:0]             sync_r;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt_r;
  logic [BW-1:0]          bit_cnt_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   perr_r;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] word,
                                           input logic par_bit);
    return ((^word) ^ par_bit) != PAR_ODD;
  endfunction

  assign rx_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous serial line (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Receive FSM; counters only move on tick, flags/data are updated at mid-stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tick_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      perr_r     <= 1'b0;
      data_out   <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r    <= START;
            tick_cnt_r <= '0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_r == TICK_MID) begin
              tick_cnt_r <= '0;
              if (!rx_s) begin
                state_r   <= DATA;
                bit_cnt_r <= '0;
                perr_r    <= 1'b0;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state_r <= IDLE;
                busy    <= 1'b0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= '0;
              shift_r    <= {rx_s, shift_r[DATA_BITS-1:1]};
              bit_cnt_r  <= bit_cnt_r + 1'b1;
              if (bit_cnt_r == BIT_LAST) begin
                state_r <= PAR_EN ? PARITY : STOP;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= '0;
              perr_r     <= parity_mismatch(shift_r, rx_s);
              state_r    <= STOP;
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt_r == TICK_END) begin
              // Leave at mid-stop so a back-to-back start edge is not missed.
              tick_cnt_r <= '0;
              data_out   <= shift_r;
              frame_err  <= ~rx_s;
              parity_err <= perr_r;
              rx_done    <= 1'b1;
              busy       <= 1'b0;
              state_r    <= IDLE;
            end else begin
              tick_cnt_r <= tick_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          tick_cnt_r <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
